// File: rtl/gen_write_sequencer.sv
// Sequences host pin writes and an 8-step pattern player onto the signal_generator write bus.
// Latency: a host edge reaches gen_addr/gen_data 2 cycles later and gen_wr 3 cycles later; one write per 4 cycles.
// Backpressure: one pending slot per source; a newer request overwrites an unissued one and raises host_ovr/seq_miss.
// Optional: define SEQ_ONESHOT_EN to add seq_oneshot/seq_done (player stops after one pass).
module gen_write_sequencer #(
    parameter int DEPTH  = 8,
    parameter int TICK_W = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              host_wr,
    input  logic [2:0]        host_addr,
    input  logic [4:0]        host_data,
    input  logic              pat_we,
    input  logic [IDX_W-1:0]  pat_idx,
    input  logic [8:0]        pat_entry,
    input  logic              seq_run,
    input  logic [IDX_W-1:0]  seq_len,
    input  logic [TICK_W-1:0] tempo,
    output logic              gen_wr,
    output logic [2:0]        gen_addr,
    output logic [4:0]        gen_data,
    output logic              busy,
    output logic [IDX_W-1:0]  step,
    output logic              host_ovr,
    output logic              seq_miss
`ifdef SEQ_ONESHOT_EN
    ,
    input  logic              seq_oneshot,
    output logic              seq_done
`endif
);

    typedef enum logic [1:0] {B_IDLE, B_SETUP, B_STROBE, B_HOLD} bus_state_e;

    bus_state_e        state_q, state_d;
    logic              host_wr_q;
    logic              hp_v_q, host_ovr_q;
    logic [2:0]        hp_addr_q;
    logic [4:0]        hp_data_q;
    logic [TICK_W-1:0] cnt_q;
    logic [IDX_W-1:0]  step_q;
    logic              sp_v_q, seq_miss_q;
    logic [2:0]        sp_addr_q;
    logic [4:0]        sp_data_q;
    logic [8:0]        ram_q [DEPTH];
    logic [2:0]        gen_addr_q;
    logic [4:0]        gen_data_q;
    logic              done_q;

    logic       host_edge, grant, grant_h, grant_s, tick, step_last, run_ok;
    logic [8:0] rd_entry;

    assign host_edge = host_wr & ~host_wr_q;
    assign grant     = (state_q == B_IDLE) & en & (hp_v_q | sp_v_q);
    assign grant_h   = grant & hp_v_q;
    assign grant_s   = grant & ~hp_v_q;
    assign run_ok    = seq_run & en & ~done_q;
    assign tick      = run_ok & (cnt_q == tempo);
    // step > seq_len can happen when seq_len shrinks at runtime; treat it as the wrap point too
    assign step_last = (step_q >= seq_len);
    assign rd_entry  = ram_q[step_q];

    // Host request capture: edge detect, single pending slot with overwrite flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_wr_q  <= 1'b0;
            hp_v_q     <= 1'b0;
            hp_addr_q  <= '0;
            hp_data_q  <= '0;
            host_ovr_q <= 1'b0;
        end else begin
            host_wr_q <= host_wr;
            if (host_edge) begin
                hp_v_q    <= 1'b1;
                hp_addr_q <= host_addr;
                hp_data_q <= host_data;
                if (hp_v_q && !grant_h) host_ovr_q <= 1'b1;
            end else if (grant_h) begin
                hp_v_q <= 1'b0;
            end
        end
    end

    // Tempo counter: period tempo+1, cleared whenever the player is stopped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!seq_run) begin
            cnt_q <= '0;
        end else if (run_ok) begin
            cnt_q <= tick ? '0 : cnt_q + TICK_W'(1);
        end
    end

    // Pattern player: load the current entry on a tick and advance the step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q     <= '0;
            sp_v_q     <= 1'b0;
            sp_addr_q  <= '0;
            sp_data_q  <= '0;
            seq_miss_q <= 1'b0;
        end else if (!seq_run) begin
            step_q <= '0;
            sp_v_q <= 1'b0;
        end else if (tick) begin
            sp_v_q    <= rd_entry[8];
            sp_addr_q <= rd_entry[7:5];
            sp_data_q <= rd_entry[4:0];
            step_q    <= step_last ? '0 : step_q + IDX_W'(1);
            if (sp_v_q && !grant_s) seq_miss_q <= 1'b1;
        end else if (grant_s) begin
            sp_v_q <= 1'b0;
        end
    end

`ifdef SEQ_ONESHOT_EN
    // One-shot completion: latch after the last-step tick, release when the player stops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (!seq_run) begin
            done_q <= 1'b0;
        end else if (tick && seq_oneshot && step_last) begin
            done_q <= 1'b1;
        end
    end
    assign seq_done = done_q;
`else
    assign done_q = 1'b0;
`endif

    // Pattern RAM: a same-cycle tick read sees the pre-write contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
        end else if (pat_we) begin
            ram_q[pat_idx] <= pat_entry;
        end
    end

    // Bus state register and granted address/data, held until the next grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= B_IDLE;
            gen_addr_q <= '0;
            gen_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gen_addr_q <= hp_v_q ? hp_addr_q : sp_addr_q;
                gen_data_q <= hp_v_q ? hp_data_q : sp_data_q;
            end
        end
    end

    // Bus next-state: setup, one-cycle strobe, hold, then back to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            B_IDLE:   if (grant) state_d = B_SETUP;
            B_SETUP:  state_d = B_STROBE;
            B_STROBE: state_d = B_HOLD;
            B_HOLD:   state_d = B_IDLE;
            default:  state_d = B_IDLE;
        endcase
    end

    assign gen_wr   = (state_q == B_STROBE);
    assign busy     = (state_q != B_IDLE);
    assign gen_addr = gen_addr_q;
    assign gen_data = gen_data_q;
    assign step     = step_q;
    assign host_ovr = host_ovr_q;
    assign seq_miss = seq_miss_q;

endmodule

// File: doc/gen_write_sequencer.md
Name: gen_write_sequencer

Overview:
- Sequences and arbitrates register writes into signal_generator (write_strobe / address[2:0] / data[4:0] bus).
- Two write sources: host pin writes, and an internal 8-step pattern player running at a programmable tempo.
- Each write goes out as a clean setup/strobe/hold transaction.
- Sits between the top level's ui_in/uio_in pins and signal_generator, in the clk_scaled domain.

Parameters:
- DEPTH, 8, pattern steps; must be a power of two, index width = log2(DEPTH).
- TICK_W, 16, width of the tempo counter and of the tempo input.

Ports:
- clk  in  1  clock (clk_scaled domain)
- rst  in  1  asynchronous reset, active-high
- en  in  1  enables tick counting and new grants
- host_wr  in  1  host write request, level from pin; rising edge = one request
- host_addr  in  3  host register address
- host_data  in  5  host register data
- pat_we  in  1  pattern entry write enable
- pat_idx  in  3  pattern entry index
- pat_entry  in  9  {valid, addr[2:0], data[4:0]}
- seq_run  in  1  pattern player enable
- seq_len  in  3  last step index; steps 0..seq_len loop
- tempo  in  TICK_W  tick period minus one, in clk cycles
- gen_wr  out  1  to signal_generator write_strobe
- gen_addr  out  3  to signal_generator address
- gen_data  out  5  to signal_generator data
- busy  out  1  bus transaction in flight
- step  out  3  current pattern step
- host_ovr  out  1  sticky: host request overwritten before issue
- seq_miss  out  1  sticky: sequencer request overwritten before issue

Behaviour:
- Reset: all outputs, pattern RAM, pending registers, counters and FSM are zero; bus FSM is B_IDLE.
- Host capture:
  - host_wr is registered; edge = host_wr & ~host_wr_q.
  - An edge loads the host pending register {hp_v, addr, data} one cycle after the edge.
  - An edge while hp_v=1 and not yet granted overwrites the register and sets host_ovr.
- Tick counter:
  - Counts only while seq_run=1 and en=1.
  - When count==tempo it asserts a tick and reloads 0, so the period is tempo+1 cycles; tempo=0 ticks every cycle.
- Sequencer tick:
  - Reads RAM[step] into the sequencer pending register; sp_v = entry.valid.
  - step advances, wrapping from seq_len to 0; step>seq_len (seq_len reduced at runtime) also wraps to 0.
  - A tick while sp_v=1 and not yet granted overwrites the register and sets seq_miss.
  - Entries with valid=0 clear sp_v and issue no write, but step still advances.
- Pattern RAM:
  - Written synchronously on pat_we.
  - A tick reading the same index in the same cycle captures the old value.
- seq_run 1->0: counter cleared, step=0, sp_v cleared if not granted; an in-flight transaction completes.
- Arbitration (in B_IDLE, en=1):
  - hp_v has priority over sp_v.
  - Grant copies the winner to gen_addr/gen_data and clears its valid bit in the same edge.
  - A capture arriving in the grant cycle for the same source counts as new (sets no flag).
- Bus FSM:
  - B_IDLE -> (grant) B_SETUP, gen_wr=0 -> B_STROBE, gen_wr=1 for exactly 1 cycle -> B_HOLD, gen_wr=0 -> B_IDLE.
  - gen_addr/gen_data are stable from B_SETUP through B_HOLD and retain their value in B_IDLE.
  - busy=1 in B_SETUP/B_STROBE/B_HOLD.
  - Back-to-back writes: 3 cycles each, plus 1 idle cycle for the next grant, giving a 4-cycle throughput.
- en=0: tick counter and grants freeze; host capture continues; an in-flight transaction completes.
- Host writes every ≤4 cycles starve the sequencer; seq_miss reports this, by design.
- Mid-operation reset: gen_wr drops asynchronously, and everything returns to reset values.

Optional Feature:
- Macro: SEQ_ONESHOT_EN.
- With the macro defined:
  - Adds input seq_oneshot and output seq_done.
  - When seq_oneshot=1, the player stops ticking after the step-seq_len tick.
  - seq_done=1 (and step=0) from that point until seq_run falls; seq_done then clears.
- Without the macro: the ports are absent, and the player always loops.

Test Plan:
- Reset, then one host edge with addr=3, data=0x15 -> gen_addr=3 and gen_data=0x15 from cycle+2, gen_wr high on cycle+3 only, busy low after cycle+4.
- Load RAM[0..2] = {1,1,0x04}, {0,x,x}, {1,2,0x1F}; seq_len=2, tempo=9; seq_run=1 -> writes (1,0x04) and (2,0x1F) every 10 cycles, step 1 skipped, step wraps 2->0.
- Host edge in the same cycle as a tick -> host write issues first, sequencer write follows 4 cycles later, no flags set.
- Two host edges 2 cycles apart while the bus is busy -> only the second data is issued, host_ovr=1.
- tempo=0 with all entries valid -> ticks every cycle outrun the 4-cycle bus, seq_miss=1, step still cycles 0..seq_len.
- Assert rst during B_STROBE -> gen_wr=0 immediately, all outputs 0; with SEQ_ONESHOT_EN, seq_len=1 and oneshot -> exactly 2 ticks, then seq_done=1.
